hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage core. It drives the stall/bubble select of the ID-stage control mux, the PC and IF/ID write enables, and the pipeline flushes. It detects load-use hazards, freezes the pipeline while data memory is busy, flushes wrong-path instructions on a taken branch resolved in MEM, and keeps saturating hazard statistics. It sits in ID beside the control unit and consumes EX/MEM pipeline-register fields.

## Interface
- CNT_W, 16, width of each statistics counter
- TIMEOUT, 255, dmem_busy cycles tolerated before mem_timeout sets (1..2^16-1)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_uses_rs2  in  1  ID instruction reads rs2 (R/S/B types)
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- mem_branch_taken  in  1  taken branch/jump resolved in MEM this cycle (1-cycle pulse)
- dmem_busy  in  1  data memory has not completed the MEM-stage access
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register write enable
- control_mux_sel  out  1  1 = zero ID control signals (bubble into ID/EX)
- pipe_hold  out  1  1 = hold ID/EX, EX/MEM, MEM/WB registers
- if_id_flush, ex_mem_flush  out  1  clear the respective pipeline register
- mem_timeout  out  1  sticky error: dmem_busy exceeded TIMEOUT cycles
- bubble_count, freeze_count, flush_count  out  CNT_W  saturating statistics

## Operation
- Load-use hazard (lu): ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2)).
- FSM states: RUN, FREEZE, FLUSH_PEND.
- RUN, dmem_busy=0, mem_branch_taken=1: flush cycle. if_id_flush=1, control_mux_sel=1, ex_mem_flush=1, pc_write=1 (branch target loaded), if_id_write=1. flush_count += 1. lu is ignored.
- RUN, dmem_busy=0, no branch, lu=1: bubble cycle. pc_write=0, if_id_write=0, control_mux_sel=1. bubble_count += 1.
- RUN, dmem_busy=1: freeze cycle, then go to FREEZE. A coincident mem_branch_taken is latched as pending.
- FREEZE, and any cycle with dmem_busy=1: pc_write=0, if_id_write=0, pipe_hold=1, control_mux_sel=0, no flushes. freeze_count += 1 per cycle. mem_branch_taken arriving during a freeze is also latched.
- Busy counter: increments each dmem_busy cycle and clears when dmem_busy=0. When it reaches TIMEOUT, mem_timeout sets and stays set until reset.
- Leaving FREEZE (dmem_busy=0): go to FLUSH_PEND if a branch is pending, else RUN. The exit cycle behaves as RUN.
- FLUSH_PEND: one flush cycle with the same outputs as the RUN flush case. Clear pending, return to RUN.
- Default outputs (no event): pc_write=1, if_id_write=1, all others 0.
- Priority: reset > dmem_busy freeze > flush (live or pending) > load-use bubble.
- Counters saturate at all-ones; they never wrap.

## Timing
- Hazard outputs are combinational from inputs and current state, with zero-cycle latency. Stall and flush take effect at the same clock edge as the triggering condition.
- A load-use bubble lasts exactly one cycle. The next cycle the load is in MEM, lu is naturally false, and forwarding covers the hazard.
- A pending flush issues exactly 1 cycle after dmem_busy falls, in the FLUSH_PEND state.
- Reset values: state=RUN, pending=0, busy counter=0, mem_timeout=0, all statistics counters=0. While reset is high, outputs equal the default outputs.
- Reset asserted mid-freeze or with a flush pending discards the pending flush; the core restarts from the reset PC.

## Structure
- Package hazard_pkg: state enum (RUN, FREEZE, FLUSH_PEND), REG_ADDR_W=5, REG_X0=5'd0.
- Sub-module sat_counter (parameter W; inputs clk, reset, inc; output count). Instantiated for bubble_count, freeze_count and flush_count.
- The busy-cycle counter is local and 16 bits wide.

## Test plan
- Load x5 in EX (ex_mem_read=1, ex_rd=5), ID add reads rs1=5 -> one cycle with pc_write=0, if_id_write=0, control_mux_sel=1; bubble_count=1.
- ex_rd=0 with ex_mem_read=1, id_rs1=0 -> no stall (x0 exempt). id_uses_rs2=0 with rs2 matching -> no stall.
- mem_branch_taken pulse with lu=1 in the same cycle -> flush cycle only (if_id_flush=1, ex_mem_flush=1, control_mux_sel=1, pc_write=1); bubble_count unchanged; flush_count=1.
- dmem_busy high for 3 cycles with mem_branch_taken in the 2nd -> pipe_hold=1 for 3 cycles, freeze_count=3; the flush cycle occurs the cycle after dmem_busy falls.
- TIMEOUT=4, dmem_busy held 6 cycles -> mem_timeout rises after the 4th busy cycle and stays high after busy drops, until reset.
- CNT_W=2, 5 load-use bubbles -> bubble_count saturates at 3. Async reset asserted mid-freeze -> all counters 0, state RUN, default outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Register-file addressing and the hazard FSM state encoding live here.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FREEZE     = 2'd1,
        FLUSH_PEND = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, dmem freeze, branch flushes
// (including flushes deferred across a freeze), busy timeout and statistics.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  mem_branch_taken,
    input  logic                  dmem_busy,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  control_mux_sel,
    output logic                  pipe_hold,
    output logic                  if_id_flush,
    output logic                  ex_mem_flush,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      bubble_count,
    output logic [CNT_W-1:0]      freeze_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic [15:0] busy_cnt_q, busy_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic        lu;
    logic        bubble_inc, freeze_inc, flush_inc;

    assign lu = ex_mem_read && (ex_rd != REG_X0) &&
                ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves one unassigned and no latch is inferred.
    always_comb begin
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        control_mux_sel = 1'b0;
        pipe_hold       = 1'b0;
        if_id_flush     = 1'b0;
        ex_mem_flush    = 1'b0;
        bubble_inc      = 1'b0;
        freeze_inc      = 1'b0;
        flush_inc       = 1'b0;
        state_d         = state_q;
        pending_d       = pending_q;

        // Outputs stay at their defaults while reset is held.
        if (!reset) begin
            if (dmem_busy) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_hold   = 1'b1;
                freeze_inc  = 1'b1;
                state_d     = FREEZE;
                pending_d   = pending_q | mem_branch_taken;
            end else begin
                state_d = (state_q == FREEZE && pending_q) ? FLUSH_PEND : RUN;
                if ((state_q == FLUSH_PEND) || mem_branch_taken) begin
                    if_id_flush     = 1'b1;
                    ex_mem_flush    = 1'b1;
                    control_mux_sel = 1'b1;
                    flush_inc       = 1'b1;
                    if (state_q == FLUSH_PEND) begin
                        pending_d = 1'b0;
                    end
                end else if (lu) begin
                    pc_write        = 1'b0;
                    if_id_write     = 1'b0;
                    control_mux_sel = 1'b1;
                    bubble_inc      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy_cnt_d    = 16'd0;
        mem_timeout_d = mem_timeout_q;
        if (dmem_busy) begin
            busy_cnt_d = (busy_cnt_q == 16'hFFFF) ? busy_cnt_q : busy_cnt_q + 16'd1;
            // This busy cycle is number busy_cnt_q+1; flag once it reaches TIMEOUT.
            if (busy_cnt_q >= TIMEOUT_M1) begin
                mem_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pending_q     <= 1'b0;
            busy_cnt_q    <= 16'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            busy_cnt_q    <= busy_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble_inc),
        .count (bubble_count)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (freeze_inc),
        .count (freeze_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares every cycle.
module tb_hazard_unit;

    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 4;

    // {pc_write, if_id_write, control_mux_sel, pipe_hold, if_id_flush, ex_mem_flush}
    localparam logic [5:0] O_DEF = 6'b110000;
    localparam logic [5:0] O_BUB = 6'b001000;
    localparam logic [5:0] O_FLU = 6'b111011;
    localparam logic [5:0] O_FRZ = 6'b000100;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs2, ex_mem_read, mem_branch_taken, dmem_busy;
    logic             pc_write, if_id_write, control_mux_sel, pipe_hold;
    logic             if_id_flush, ex_mem_flush, mem_timeout;
    logic [CNT_W-1:0] bubble_count, freeze_count, flush_count;

    typedef struct {
        string      name;
        logic [5:0] outs;
        logic       tmo;
        logic [1:0] b;
        logic [1:0] f;
        logic [1:0] fl;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    hazard_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_uses_rs2      (id_uses_rs2),
        .ex_rd            (ex_rd),
        .ex_mem_read      (ex_mem_read),
        .mem_branch_taken (mem_branch_taken),
        .dmem_busy        (dmem_busy),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .control_mux_sel  (control_mux_sel),
        .pipe_hold        (pipe_hold),
        .if_id_flush      (if_id_flush),
        .ex_mem_flush     (ex_mem_flush),
        .mem_timeout      (mem_timeout),
        .bubble_count     (bubble_count),
        .freeze_count     (freeze_count),
        .flush_count      (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus just after the rising edge and queue its expectation.
    task automatic vec(input string nm, input logic rst, input logic busy, input logic br,
                       input logic mrd, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u2, input logic [5:0] o,
                       input logic t, input logic [1:0] b, input logic [1:0] f,
                       input logic [1:0] fl);
        exp_t e;
        @(posedge clk);
        #1;
        reset            = rst;
        dmem_busy        = busy;
        mem_branch_taken = br;
        ex_mem_read      = mrd;
        ex_rd            = rd;
        id_rs1           = rs1;
        id_rs2           = rs2;
        id_uses_rs2      = u2;
        e.name = nm;
        e.outs = o;
        e.tmo  = t;
        e.b    = b;
        e.f    = f;
        e.fl   = fl;
        sb.push_back(e);
    endtask

    task automatic idle(input string nm, input logic rst, input logic [5:0] o, input logic t,
                        input logic [1:0] b, input logic [1:0] f, input logic [1:0] fl);
        vec(nm, rst, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, o, t, b, f, fl);
    endtask

    task automatic busy(input string nm, input logic br, input logic t,
                        input logic [1:0] b, input logic [1:0] f, input logic [1:0] fl);
        vec(nm, 1'b0, 1'b1, br, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, O_FRZ, t, b, f, fl);
    endtask

    // Monitor: outputs are valid every cycle; compare at the falling edge.
    initial begin
        exp_t e;
        logic [12:0] act, req;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                act = {pc_write, if_id_write, control_mux_sel, pipe_hold, if_id_flush,
                       ex_mem_flush, mem_timeout, bubble_count, freeze_count, flush_count};
                req = {e.outs, e.tmo, e.b, e.f, e.fl};
                n_checks++;
                if (act !== req) begin
                    n_fail++;
                    $display("FAIL %s: got outs=%b tmo=%b cnt b/f/fl=%0d/%0d/%0d, want outs=%b tmo=%b cnt b/f/fl=%0d/%0d/%0d",
                             e.name, act[12:7], act[6], act[5:4], act[3:2], act[1:0],
                             req[12:7], req[6], req[5:4], req[3:2], req[1:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; dmem_busy = 1'b0; mem_branch_taken = 1'b0; ex_mem_read = 1'b0;
        ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;

        // Reset held with every hazard input active: default outputs.
        vec("rst_hold", 1, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0, O_DEF, 0, 0, 0, 0);
        idle("idle", 0, O_DEF, 0, 0, 0, 0);

        // Load-use detection and exemptions.
        vec("lu_rs1",     0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, O_BUB, 0, 0, 0, 0);
        idle("lu_clear", 0, O_DEF, 0, 1, 0, 0);
        vec("x0_exempt",  0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, O_DEF, 0, 1, 0, 0);
        vec("rs2_unused", 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, O_DEF, 0, 1, 0, 0);
        vec("lu_rs2",     0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 1, O_BUB, 0, 1, 0, 0);
        vec("no_load",    0, 0, 0, 0, 5'd7, 5'd3, 5'd7, 1, O_DEF, 0, 2, 0, 0);

        // Live branch overrides a coincident load-use.
        vec("br_over_lu", 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, O_FLU, 0, 2, 0, 0);
        idle("after_br", 0, O_DEF, 0, 2, 0, 1);

        // Three busy cycles, branch in the second: flush one cycle after busy falls.
        busy("frz1",    0, 0, 2, 0, 1);
        busy("frz2_br", 1, 0, 2, 1, 1);
        busy("frz3",    0, 0, 2, 2, 1);
        idle("frz_exit",   0, O_DEF, 0, 2, 3, 1);
        idle("pend_flush", 0, O_FLU, 0, 2, 3, 1);
        idle("post_flush", 0, O_DEF, 0, 2, 3, 2);

        // Six busy cycles with TIMEOUT=4: flag visible after the 4th, then sticky.
        busy("tmo_busy1", 0, 0, 2, 3, 2);
        busy("tmo_busy2", 0, 0, 2, 3, 2);
        busy("tmo_busy3", 0, 0, 2, 3, 2);
        busy("tmo_busy4", 0, 0, 2, 3, 2);
        busy("tmo_busy5", 0, 1, 2, 3, 2);
        busy("tmo_busy6", 0, 1, 2, 3, 2);
        idle("tmo_exit",   0, O_DEF, 1, 2, 3, 2);
        idle("tmo_sticky", 0, O_DEF, 1, 2, 3, 2);

        // Branch coincident with the first busy cycle is latched.
        busy("busy_br",   1, 1, 2, 3, 2);
        idle("busy_exit",   0, O_DEF, 1, 2, 3, 2);
        idle("coinc_flush", 0, O_FLU, 1, 2, 3, 2);
        idle("after_coinc", 0, O_DEF, 1, 2, 3, 3);

        // Async reset mid-freeze with a flush pending: immediate clear, pending dropped.
        busy("busy_br2", 1, 1, 2, 3, 3);
        vec("rst_mid", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_DEF, 0, 0, 0, 0);
        idle("rst_hold2", 1, O_DEF, 0, 0, 0, 0);
        busy("post_rst_busy", 0, 0, 0, 0, 0);
        idle("post_rst_exit", 0, O_DEF, 0, 0, 1, 0);
        idle("no_pend_flush", 0, O_DEF, 0, 0, 1, 0);

        // Five consecutive bubbles saturate a 2-bit counter at 3.
        vec("sat_lu1", 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 0, O_BUB, 0, 0, 1, 0);
        vec("sat_lu2", 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 0, O_BUB, 0, 1, 1, 0);
        vec("sat_lu3", 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 0, O_BUB, 0, 2, 1, 0);
        vec("sat_lu4", 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 0, O_BUB, 0, 3, 1, 0);
        vec("sat_lu5", 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 0, O_BUB, 0, 3, 1, 0);
        idle("sat_hold", 0, O_DEF, 0, 3, 1, 0);

        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d expectations left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
